button_bank: RTL and testbench

//  Parametrised N-channel replacement for per-button debouncer instances on the clock shield.
//  Per channel: synchronises raw input, debounces it, and emits a level plus press/release pulses.

---
 rtl/button_bank.sv | 122 ++++++++++++
 tb/tb_button_bank.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// N-channel button synchroniser/debouncer with level, press and release outputs.
// Define BUTTON_BANK_AUTOREPEAT_EN to add hold-to-repeat pulses on repeat_pulse.

module button_chan #(
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter bit   INV             = 1'b0,
    parameter int   REPEAT_DELAY    = 25000000,
    parameter int   REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pressed,
    output logic released,
    output logic repeat_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          flip;

    // Level changes when a mismatch arrives with the counter already at its last value.
    assign flip = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            sync1    <= btn ^ INV;
            sync2    <= sync1;
            pressed  <= 1'b0;
            released <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level    <= sync2;
                cnt      <= '0;
                pressed  <= sync2;
                released <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef BUTTON_BANK_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] target;
    logic          first;

    // First interval after the press is the long delay, later ones the period.
    assign target = first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt         <= '0;
            first        <= 1'b1;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (!level || flip) begin
                rcnt  <= '0;
                first <= 1'b1;
            end else if (rcnt + RW'(1) == target) begin
                repeat_pulse <= 1'b1;
                rcnt         <= '0;
                first        <= 1'b0;
            end else begin
                rcnt <= rcnt + RW'(1);
            end
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif
endmodule

module button_bank #(
    parameter int                  CHANNELS        = 3,
    parameter int                  DEBOUNCE_CYCLES = 1000000,
    parameter logic [CHANNELS-1:0] INVERT          = {CHANNELS{1'b0}},
    parameter int                  REPEAT_DELAY    = 25000000,
    parameter int                  REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic                any_pressed
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        button_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INV            (INVERT[i]),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .btn         (btn_in[i]),
            .level       (level[i]),
            .pressed     (pressed[i]),
            .released    (released[i]),
            .repeat_pulse(repeat_pulse[i])
        );
    end

    assign any_pressed = |level;
endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: idle, inversion, press, bounce, release, auto-repeat, reset.
// Repeat expectations follow BUTTON_BANK_AUTOREPEAT_EN as compiled.

module tb_button_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_in = 3'b010;
    logic [2:0] level, pressed, released, repeat_pulse;
    logic       any_pressed;

    int checks = 0;
    int errs   = 0;

    button_bank #(
        .CHANNELS(3), .DEBOUNCE_CYCLES(4), .INVERT(3'b010),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .level(level),
        .pressed(pressed), .released(released), .repeat_pulse(repeat_pulse),
        .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rep_exp(input int k);
`ifdef BUTTON_BANK_AUTOREPEAT_EN
        return (k == 20) || (k == 28) || (k == 36);
`else
        return (k < 0);
`endif
    endfunction

    initial begin
        logic [2:0] acc;

        // Reset
        tick(); tick();
        chk("rst_level", level, 3'b000);
        chk("rst_pulses", {pressed, released, repeat_pulse}, 9'b0);
        rst = 1'b0;

        // 1. idle with ch1 inverted high
        acc = '0;
        for (int i = 0; i < 100; i++) begin
            tick();
            acc |= level | pressed | released | repeat_pulse;
        end
        chk("idle_quiet", acc, 3'b000);

        btn_in[1] = 1'b0;
        acc = '0;
        for (int i = 0; i < 5; i++) begin tick(); acc |= level | pressed; end
        chk("ch1_early", acc, 3'b000);
        tick();
        chk("ch1_pressed", pressed, 3'b010);
        chk("ch1_level", level, 3'b010);
        tick();
        chk("ch1_pressed_width", pressed, 3'b000);

        btn_in[1] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("ch1_rel_early", released, 3'b000);
        tick();
        chk("ch1_released", released, 3'b010);
        chk("ch1_level_off", level, 3'b000);

        // 2. press ch0, 5. repeat while held, 4. release
        btn_in[0] = 1'b1;
        acc = '0;
        for (int i = 0; i < 5; i++) begin tick(); acc |= level | pressed; end
        chk("ch0_early", acc, 3'b000);
        tick();
        chk("ch0_pressed", pressed, 3'b001);
        chk("ch0_level", level, 3'b001);
        chk("ch0_any", any_pressed, 1'b1);
        chk("ch0_no_rel", released, 3'b000);

        for (int k = 1; k <= 80; k++) begin
            tick();
            chk($sformatf("rep_k%0d", k), repeat_pulse, {2'b00, rep_exp(k)});
            if (k == 1) chk("ch0_pressed_width", pressed, 3'b000);
            if (k == 39) chk("ch0_still_held", level, 3'b001);
            if (k == 40) begin
                chk("ch0_released", released, 3'b001);
                chk("ch0_level_off", level, 3'b000);
                chk("ch0_any_off", any_pressed, 1'b0);
                chk("ch0_no_press", pressed, 3'b000);
            end
            if (k == 41) chk("ch0_rel_width", released, 3'b000);
            if (k == 34) btn_in[0] = 1'b0;
        end

        // 3. bounce on ch2, runs of 3 samples never qualify
        acc = '0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_in[2] = ~btn_in[2];
            tick();
            acc |= level | pressed | released;
        end
        btn_in[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); acc |= level | pressed | released; end
        chk("bounce_quiet", acc, 3'b000);

        // 6. reset with ch0 held and ch2 counter at 2
        btn_in[0] = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_rst_level", level, 3'b001);
        btn_in[2] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_ch2_off", level, 3'b001);
        rst = 1'b1;
        tick();
        chk("mid_rst_level", level, 3'b000);
        chk("mid_rst_pulses", {pressed, released, repeat_pulse}, 9'b0);
        chk("mid_rst_any", any_pressed, 1'b0);
        rst = 1'b0;
        acc = '0;
        for (int i = 0; i < 5; i++) begin tick(); acc |= level | pressed | released; end
        chk("post_rst_silent", acc, 3'b000);
        tick();
        chk("post_rst_pressed", pressed, 3'b101);
        chk("post_rst_level", level, 3'b101);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
